// File: rtl/sb_pkg.sv
// Shared types and constants for the scoreboard issue controller.
// The popcount helper lets checkers confirm the busy counter tracks the busy vector.
package sb_pkg;

    localparam int NUM_REGS_DEF = 32;
    localparam int IDX_W_DEF    = $clog2(NUM_REGS_DEF);
    localparam int MAX_REGS     = 256;

    typedef logic [IDX_W_DEF-1:0] reg_idx_t;

    function automatic int unsigned popcount(input logic [MAX_REGS-1:0] v);
        int unsigned c;
        c = 32'd0;
        for (int i = 0; i < MAX_REGS; i++) begin
            c = c + {31'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/sb_issue_ctrl_chk.sv
// Assertion checker: the registered busy count must always equal the number of
// busy registers, and register 0 must never be marked busy.
module sb_issue_ctrl_chk
    import sb_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int CNT_W    = $clog2(NUM_REGS) + 1
) (
    input logic                clk,
    input logic                rst,
    input logic [NUM_REGS-1:0] busy,
    input logic [CNT_W-1:0]    busy_cnt
);

    logic [MAX_REGS-1:0] w_busy_ext;

    assign w_busy_ext = MAX_REGS'(busy);

    a_cnt_matches: assert property (@(posedge clk) disable iff (rst)
        busy_cnt == CNT_W'(popcount(w_busy_ext)));

    a_reg0_free: assert property (@(posedge clk) disable iff (rst) !busy[0]);

endmodule

// File: rtl/sb_issue_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr with wrap and
// grants the first active request. The pointer register lives in the caller.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    // rotating priority search starting at ptr
    always_comb begin
        int idx;
        idx     = 0;
        gnt     = {N{1'b0}};
        gnt_idx = {PW{1'b0}};
        any     = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end else begin
                idx = idx;
            end
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = PW'(idx);
                any      = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/sb_issue_ctrl.sv
// Scoreboard between decode and execute: tracks busy registers, stalls issue on
// RAW/WAW hazards and round-robins writebacks onto the single RF write port.
module sb_issue_ctrl
    import sb_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_WB   = 2,
    parameter int IDX_W    = $clog2(NUM_REGS),
    parameter int WB_W     = (NUM_WB > 1) ? $clog2(NUM_WB) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    issue_valid,
    output logic                    issue_ready,
    input  logic [IDX_W-1:0]        issue_rs1,
    input  logic                    issue_rs1_en,
    input  logic [IDX_W-1:0]        issue_rs2,
    input  logic                    issue_rs2_en,
    input  logic [IDX_W-1:0]        issue_rd,
    input  logic                    issue_rd_en,
    input  logic [NUM_WB-1:0]       wb_valid,
    input  logic [NUM_WB*IDX_W-1:0] wb_rd,
    output logic [NUM_WB-1:0]       wb_ready,
    output logic                    rf_we,
    output logic [IDX_W-1:0]        rf_waddr,
    output logic [WB_W-1:0]         rf_wsel,
    output logic [IDX_W:0]          busy_cnt,
    output logic                    wb_err
);

    logic [NUM_REGS-1:0] r_busy;
    logic [WB_W-1:0]     r_rr_ptr;
    logic                r_wb_err;
    logic [IDX_W:0]      r_busy_cnt;

    logic                w_hazard;
    logic                w_fire;
    logic [NUM_WB-1:0]   w_req;
    logic [NUM_WB-1:0]   w_gnt;
    logic [WB_W-1:0]     w_gnt_idx;
    logic                w_any;
    logic [IDX_W-1:0]    w_waddr;

    logic                w_set_en;
    logic                w_clr_en;
    logic                w_spurious;
    logic                w_eff_set;
    logic                w_eff_clr;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic [IDX_W:0]      w_cnt_nxt;
    logic [WB_W-1:0]     w_ptr_nxt;
    logic                w_err_nxt;

    // hazard check against registered busy only; no writeback bypass
    always_comb begin
        w_hazard = (issue_rs1_en & r_busy[issue_rs1])
                 | (issue_rs2_en & r_busy[issue_rs2])
                 | (issue_rd_en  & r_busy[issue_rd]);
    end

    assign issue_ready = ~rst & ~flush & ~w_hazard;
    assign w_fire      = issue_valid & issue_ready;
    assign w_req       = rst ? {NUM_WB{1'b0}} : wb_valid;

    rr_arbiter #(
        .N  (NUM_WB),
        .PW (WB_W)
    ) u_arb (
        .req     (w_req),
        .ptr     (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    // select the granted requester's destination; zero when nothing is granted
    always_comb begin
        w_waddr = {IDX_W{1'b0}};
        for (int i = 0; i < NUM_WB; i++) begin
            if (w_gnt[i]) begin
                w_waddr = wb_rd[i*IDX_W +: IDX_W];
            end else begin
                w_waddr = w_waddr;
            end
        end
    end

    assign wb_ready = w_gnt;
    assign rf_we    = w_any;
    assign rf_waddr = w_waddr;
    assign rf_wsel  = w_gnt_idx;
    assign busy_cnt = r_busy_cnt;
    assign wb_err   = r_wb_err;

    // next-state: issue sets, writeback clears, set wins on collision, flush wipes busy
    always_comb begin
        w_set_en   = w_fire & issue_rd_en & (issue_rd != {IDX_W{1'b0}});
        w_clr_en   = w_any & (w_waddr != {IDX_W{1'b0}});
        w_spurious = w_clr_en & ~r_busy[w_waddr];
        w_eff_set  = w_set_en & ~r_busy[issue_rd];
        w_eff_clr  = w_clr_en & r_busy[w_waddr] & ~(w_set_en & (issue_rd == w_waddr));

        w_busy_nxt = r_busy;
        if (w_clr_en) begin
            w_busy_nxt[w_waddr] = 1'b0;
        end else begin
            w_busy_nxt = w_busy_nxt;
        end
        if (w_set_en) begin
            w_busy_nxt[issue_rd] = 1'b1;
        end else begin
            w_busy_nxt = w_busy_nxt;
        end

        case ({w_eff_set, w_eff_clr})
            2'b10:   w_cnt_nxt = r_busy_cnt + {{IDX_W{1'b0}}, 1'b1};
            2'b01:   w_cnt_nxt = r_busy_cnt - {{IDX_W{1'b0}}, 1'b1};
            default: w_cnt_nxt = r_busy_cnt;
        endcase

        if (flush) begin
            w_busy_nxt = {NUM_REGS{1'b0}};
            w_cnt_nxt  = {(IDX_W+1){1'b0}};
        end else begin
            w_cnt_nxt = w_cnt_nxt;
        end

        if (!w_any) begin
            w_ptr_nxt = r_rr_ptr;
        end else if (w_gnt_idx == WB_W'(NUM_WB - 1)) begin
            w_ptr_nxt = {WB_W{1'b0}};
        end else begin
            w_ptr_nxt = w_gnt_idx + {{(WB_W-1){1'b0}}, 1'b1};
        end

        w_err_nxt = r_wb_err | w_spurious;
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy     <= {NUM_REGS{1'b0}};
            r_rr_ptr   <= {WB_W{1'b0}};
            r_wb_err   <= 1'b0;
            r_busy_cnt <= {(IDX_W+1){1'b0}};
        end else begin
            r_busy     <= w_busy_nxt;
            r_rr_ptr   <= w_ptr_nxt;
            r_wb_err   <= w_err_nxt;
            r_busy_cnt <= w_cnt_nxt;
        end
    end

    sb_issue_ctrl_chk #(
        .NUM_REGS (NUM_REGS),
        .CNT_W    (IDX_W + 1)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .busy     (r_busy),
        .busy_cnt (r_busy_cnt)
    );

endmodule

// File: tb/tb_sb_issue_ctrl.sv
// Self-checking bench for sb_issue_ctrl: scenario tasks check issue/busy state
// inline; every writeback grant is checked against a queue of expected grants.
module tb_sb_issue_ctrl;
    import sb_pkg::*;

    localparam int NR = 32;
    localparam int NW = 2;
    localparam int IW = 5;

    typedef struct packed {
        logic [NW-1:0] ready;
        logic          wsel;
        logic [IW-1:0] waddr;
    } wb_exp_t;

    logic          clk = 1'b0;
    logic          rst, flush, issue_valid, issue_ready;
    reg_idx_t      issue_rs1, issue_rs2, issue_rd;
    logic          issue_rs1_en, issue_rs2_en, issue_rd_en;
    logic [NW-1:0] wb_valid, wb_ready;
    logic [NW*IW-1:0] wb_rd;
    logic          rf_we;
    logic [IW-1:0] rf_waddr;
    logic          rf_wsel;
    logic [IW:0]   busy_cnt;
    logic          wb_err;

    int total = 0;
    int bad   = 0;
    wb_exp_t exp_q[$];
    wb_exp_t mon_e;

    always #5 clk = ~clk;

    sb_issue_ctrl #(.NUM_REGS(NR), .NUM_WB(NW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1(issue_rs1), .issue_rs1_en(issue_rs1_en),
        .issue_rs2(issue_rs2), .issue_rs2_en(issue_rs2_en),
        .issue_rd(issue_rd), .issue_rd_en(issue_rd_en),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_ready(wb_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wsel(rf_wsel),
        .busy_cnt(busy_cnt), .wb_err(wb_err)
    );

    // writeback port monitor: every cycle the grant must match the queue head or be idle
    always @(negedge clk) begin
        total++;
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL wb_unexpected: got ready=%b waddr=%0d wsel=%0d, want no grant", wb_ready, rf_waddr, rf_wsel);
            end else begin
                mon_e = exp_q.pop_front();
                if (wb_ready !== mon_e.ready || rf_waddr !== mon_e.waddr || rf_wsel !== mon_e.wsel) begin
                    bad++;
                    $display("FAIL wb_grant: got ready=%b waddr=%0d wsel=%0d, want ready=%b waddr=%0d wsel=%0d",
                             wb_ready, rf_waddr, rf_wsel, mon_e.ready, mon_e.waddr, mon_e.wsel);
                end
            end
        end else if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            bad++;
            $display("FAIL wb_missing: got rf_we=%b ready=%b, want ready=%b waddr=%0d", rf_we, wb_ready, mon_e.ready, mon_e.waddr);
        end else if (rf_we !== 1'b0 || wb_ready !== 2'b00 || rf_waddr !== 5'd0 || rf_wsel !== 1'b0) begin
            bad++;
            $display("FAIL wb_idle: got rf_we=%b ready=%b waddr=%0d wsel=%0d, want all zero", rf_we, wb_ready, rf_waddr, rf_wsel);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; issue_valid = 1'b0;
        issue_rs1 = 5'd0; issue_rs1_en = 1'b0;
        issue_rs2 = 5'd0; issue_rs2_en = 1'b0;
        issue_rd  = 5'd0; issue_rd_en  = 1'b0;
        wb_valid = 2'b00; wb_rd = 10'd0;
    endtask

    task automatic push_exp(input logic [NW-1:0] r, input logic s, input logic [IW-1:0] a);
        wb_exp_t t;
        t.ready = r; t.wsel = s; t.waddr = a;
        exp_q.push_back(t);
    endtask

    task automatic issue_write(input logic [IW-1:0] rd);
        idle();
        issue_valid = 1'b1; issue_rd = rd; issue_rd_en = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        issue_valid = 1'b1; issue_rd = 5'd5; issue_rd_en = 1'b1;
        wb_valid = 2'b11; wb_rd = {5'd4, 5'd6};
        settle();
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL rst_issue_ready: got %b want 0", issue_ready); end
        total++; if (wb_ready !== 2'b00 || rf_we !== 1'b0) begin bad++; $display("FAIL rst_wb: got ready=%b we=%b want 00/0", wb_ready, rf_we); end
        tick();
        rst = 1'b0; idle(); settle();
        total++; if (busy_cnt !== 6'd0) begin bad++; $display("FAIL rst_busy_cnt: got %0d want 0", busy_cnt); end
        total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL rst_wb_err: got %b want 0", wb_err); end
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after: got %b want 1", issue_ready); end
    endtask

    task automatic test_issue_raw();
        issue_valid = 1'b1; issue_rd = 5'd5; issue_rd_en = 1'b1; issue_rs1 = 5'd0; issue_rs1_en = 1'b1;
        settle();
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL issue_first_ready: got %b want 1", issue_ready); end
        tick();
        idle(); settle();
        total++; if (busy_cnt !== 6'd1) begin bad++; $display("FAIL issue_busy_cnt: got %0d want 1", busy_cnt); end
        issue_valid = 1'b1; issue_rs1 = 5'd5; issue_rs1_en = 1'b1; settle();
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL raw_rs1_stall: got %b want 0", issue_ready); end
        issue_rs1_en = 1'b0; issue_rs2 = 5'd5; issue_rs2_en = 1'b1; settle();
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL raw_rs2_stall: got %b want 0", issue_ready); end
        issue_rs2_en = 1'b0; settle();
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL raw_unused_src: got %b want 1", issue_ready); end
        idle();
    endtask

    task automatic test_raw_release();
        tick();
        wb_valid = 2'b01; wb_rd = {5'd0, 5'd5};
        issue_valid = 1'b1; issue_rs1 = 5'd5; issue_rs1_en = 1'b1;
        push_exp(2'b01, 1'b0, 5'd5);
        settle();
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL release_no_bypass: got %b want 0", issue_ready); end
        tick();
        wb_valid = 2'b00; settle();
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL release_next_cycle: got %b want 1", issue_ready); end
        total++; if (busy_cnt !== 6'd0) begin bad++; $display("FAIL release_busy_cnt: got %0d want 0", busy_cnt); end
        total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL release_wb_err: got %b want 0", wb_err); end
        idle();
    endtask

    task automatic test_arbitration();
        logic [IW:0] exp_cnt [3];
        logic        exp_err [3];
        exp_cnt = '{6'd1, 6'd0, 6'd0};
        exp_err = '{1'b0, 1'b0, 1'b1};
        issue_write(5'd3);
        idle();
        issue_valid = 1'b1; issue_rd = 5'd7; issue_rd_en = 1'b1;
        wb_valid = 2'b10; wb_rd = {5'd0, 5'd0};
        push_exp(2'b10, 1'b1, 5'd0);
        tick();
        idle(); settle();
        total++; if (busy_cnt !== 6'd2) begin bad++; $display("FAIL arb_setup_cnt: got %0d want 2", busy_cnt); end
        total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL arb_reg0_no_err: got %b want 0", wb_err); end
        wb_valid = 2'b11; wb_rd = {5'd7, 5'd3};
        for (int k = 0; k < 3; k++) begin
            if (k == 1) push_exp(2'b10, 1'b1, 5'd7);
            else        push_exp(2'b01, 1'b0, 5'd3);
            tick();
            if (k == 2) wb_valid = 2'b00;
            settle();
            total++; if (busy_cnt !== exp_cnt[k]) begin bad++; $display("FAIL arb_cnt_%0d: got %0d want %0d", k, busy_cnt, exp_cnt[k]); end
            total++; if (wb_err !== exp_err[k]) begin bad++; $display("FAIL arb_err_%0d: got %b want %b", k, wb_err, exp_err[k]); end
        end
        idle();
    endtask

    task automatic test_waw();
        issue_write(5'd9);
        idle(); settle();
        total++; if (busy_cnt !== 6'd1) begin bad++; $display("FAIL waw_setup_cnt: got %0d want 1", busy_cnt); end
        issue_valid = 1'b1; issue_rd = 5'd9; issue_rd_en = 1'b1; settle();
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL waw_stall: got %b want 0", issue_ready); end
        issue_rd = 5'd0; settle();
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL waw_rd0_ready: got %b want 1", issue_ready); end
        tick();
        idle(); settle();
        total++; if (busy_cnt !== 6'd1) begin bad++; $display("FAIL waw_rd0_no_set: got %0d want 1", busy_cnt); end
        wb_valid = 2'b01; wb_rd = {5'd0, 5'd9};
        push_exp(2'b01, 1'b0, 5'd9);
        tick();
        idle(); settle();
        total++; if (busy_cnt !== 6'd0) begin bad++; $display("FAIL waw_cleanup_cnt: got %0d want 0", busy_cnt); end
    endtask

    task automatic test_spurious();
        rst = 1'b1; tick();
        rst = 1'b0; idle(); settle();
        total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL spur_rst_clear: got %b want 0", wb_err); end
        wb_valid = 2'b10; wb_rd = {5'd12, 5'd0};
        push_exp(2'b10, 1'b1, 5'd12);
        settle();
        total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL spur_not_yet: got %b want 0", wb_err); end
        tick();
        wb_valid = 2'b00; settle();
        total++; if (wb_err !== 1'b1) begin bad++; $display("FAIL spur_err_set: got %b want 1", wb_err); end
        total++; if (busy_cnt !== 6'd0) begin bad++; $display("FAIL spur_no_underflow: got %0d want 0", busy_cnt); end
        issue_write(5'd12);
        idle();
        wb_valid = 2'b01; wb_rd = {5'd0, 5'd12};
        push_exp(2'b01, 1'b0, 5'd12);
        tick();
        idle(); settle();
        total++; if (wb_err !== 1'b1) begin bad++; $display("FAIL spur_sticky: got %b want 1", wb_err); end
        total++; if (busy_cnt !== 6'd0) begin bad++; $display("FAIL spur_traffic_cnt: got %0d want 0", busy_cnt); end
    endtask

    task automatic test_flush();
        for (int r = 1; r <= 4; r++) issue_write(5'(r));
        idle(); settle();
        total++; if (busy_cnt !== 6'd4) begin bad++; $display("FAIL flush_setup_cnt: got %0d want 4", busy_cnt); end
        flush = 1'b1;
        issue_valid = 1'b1; issue_rd = 5'd20; issue_rd_en = 1'b1;
        wb_valid = 2'b01; wb_rd = {5'd0, 5'd2};
        push_exp(2'b01, 1'b0, 5'd2);
        settle();
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b want 0", issue_ready); end
        tick();
        idle(); settle();
        total++; if (busy_cnt !== 6'd0) begin bad++; $display("FAIL flush_cnt: got %0d want 0", busy_cnt); end
        issue_rs1 = 5'd20; issue_rs1_en = 1'b1; issue_rs2 = 5'd1; issue_rs2_en = 1'b1;
        issue_rd = 5'd3; issue_rd_en = 1'b1; settle();
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL flush_busy_cleared: got %b want 1", issue_ready); end
        idle();
        wb_valid = 2'b11; wb_rd = {5'd0, 5'd0};
        push_exp(2'b10, 1'b1, 5'd0);
        tick();
        idle(); settle();
        total++; if (wb_err !== 1'b1) begin bad++; $display("FAIL flush_err_sticky: got %b want 1", wb_err); end
    endtask

    task automatic test_reset_mid();
        issue_write(5'd6);
        idle(); settle();
        total++; if (busy_cnt !== 6'd1) begin bad++; $display("FAIL rstmid_setup_cnt: got %0d want 1", busy_cnt); end
        rst = 1'b1;
        issue_valid = 1'b1; issue_rd = 5'd8; issue_rd_en = 1'b1;
        wb_valid = 2'b11; wb_rd = {5'd6, 5'd6};
        settle();
        total++; if (issue_ready !== 1'b0 || wb_ready !== 2'b00 || rf_we !== 1'b0) begin
            bad++; $display("FAIL rstmid_outputs: got ready=%b wb_ready=%b we=%b want 0/00/0", issue_ready, wb_ready, rf_we);
        end
        tick();
        rst = 1'b0; idle(); settle();
        total++; if (busy_cnt !== 6'd0) begin bad++; $display("FAIL rstmid_cnt: got %0d want 0", busy_cnt); end
        total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL rstmid_err: got %b want 0", wb_err); end
        issue_rs1 = 5'd6; issue_rs1_en = 1'b1; issue_rs2 = 5'd8; issue_rs2_en = 1'b1; settle();
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL rstmid_busy_clear: got %b want 1", issue_ready); end
        idle();
        wb_valid = 2'b11; wb_rd = {5'd0, 5'd0};
        push_exp(2'b01, 1'b0, 5'd0);
        tick();
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        test_reset();
        test_issue_raw();
        test_raw_release();
        test_arbitration();
        test_waw();
        test_spurious();
        test_flush();
        test_reset_mid();
        tick();
        tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending grants want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
